// File: rtl/sram_fetch_pkg.sv
// rtl/sram_fetch_pkg.sv - shared widths and state encoding for the SRAM pair fetch engine
package sram_fetch_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 19;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/pair_fifo2.sv
// rtl/pair_fifo2.sv - two-entry FIFO with a registered head entry
module pair_fifo2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;

  // Head always holds the oldest entry; the tail slot is only used when two entries are resident.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    if (pop && (occ_q == 2'd2)) begin
      head_d = tail_q;
    end else if (push && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
      head_d = din;
    end
    if (push && (((occ_q == 2'd1) && !pop) || ((occ_q == 2'd2) && pop))) begin
      tail_d = din;
    end
  end

  // Storage registers; reset empties the FIFO and zeroes the visible head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

endmodule

// File: rtl/sram_pair_fetch.sv
// rtl/sram_pair_fetch.sv - strided dual-port SRAM pair fetcher with credit-based read issue
module sram_pair_fetch
  import sram_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              CENA,
  output logic              CENB,
  output logic              WENA,
  output logic              WENB,
  output logic [ADDR_W-1:0] AA,
  output logic [ADDR_W-1:0] AB,
  output logic [DATA_W-1:0] DA,
  output logic [DATA_W-1:0] DB,
  input  logic [DATA_W-1:0] QA,
  input  logic [DATA_W-1:0] QB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] stride_a_q, stride_a_d;
  logic [ADDR_W-1:0] stride_b_q, stride_b_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic [1:0]          occ;
  logic [2*DATA_W:0]   head;
  logic                pop;
  logic                issue;
  logic                last_issue;
  logic [LEN_W-1:0]    cnt_next;

  assign out_valid  = (occ != 2'd0);
  assign pop        = out_valid & out_ready;
  assign cnt_next   = cnt_q + LEN_W'(1);
  assign last_issue = (cnt_next == len_q);

  // A read may go out only if buffer plus the read in flight, less this cycle's pop, leaves a free slot.
  assign issue = (state_q == ISSUE) &&
                 (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  // Next-state, address stepping and transfer bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    stride_a_d  = stride_a_q;
    stride_b_d  = stride_b_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    inflight_d  = issue;
    infl_last_d = issue && last_issue;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            addr_a_d   = base_a;
            addr_b_d   = base_b;
            stride_a_d = stride_a;
            stride_b_d = stride_b;
            len_d      = len;
            cnt_d      = '0;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_a_d = addr_a_q + stride_a_q;
          addr_b_d = addr_b_q + stride_b_q;
          cnt_d    = cnt_next;
          if (last_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset also drops any read that is still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      stride_a_q  <= stride_a_d;
      stride_b_q  <= stride_b_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  pair_fifo2 #(
    .W(2 * DATA_W + 1)
  ) u_fifo (
    .clk (CLK),
    .rst (RST),
    .push(inflight_q),
    .din ({QA, QB, infl_last_q}),
    .pop (pop),
    .occ (occ),
    .head(head)
  );

  assign out_a    = head[2*DATA_W:DATA_W+1];
  assign out_b    = head[DATA_W:1];
  assign out_last = head[0] & out_valid;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign CENA = ~issue;
  assign CENB = ~issue;
  assign WENA = 1'b1;
  assign WENB = 1'b1;
  assign AA   = addr_a_q;
  assign AB   = addr_b_q;
  assign DA   = '0;
  assign DB   = '0;

endmodule

// File: tb/tb_sram_pair_fetch.sv
// tb/tb_sram_pair_fetch.sv - scoreboard bench for sram_pair_fetch with a behavioural dual-port SRAM
module tb_sram_pair_fetch;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int LW = 19;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0, stride_a = '0, stride_b = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, CENA, CENB, WENA, WENB;
  logic [AW-1:0] AA, AB;
  logic [DW-1:0] DA, DB;
  logic [DW-1:0] QA = '0, QB = '0;
  logic          out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_a, out_b;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] exp_aa[$];
  logic [AW-1:0] exp_ab[$];
  logic [DW-1:0] mem[int];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, outst = 0;
  int done_cnt = 0, done_mark = 0, done_rel = -1;
  int ready_mode = 0, pidx = 0;
  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
  logic          prev_stall = 1'b0;
  logic [DW-1:0] pa = '0, pb = '0;
  logic          pl = 1'b0;

  sram_pair_fetch dut (
    .CLK(CLK), .RST(RST), .start(start),
    .base_a(base_a), .base_b(base_b), .stride_a(stride_a), .stride_b(stride_b), .len(len),
    .busy(busy), .done(done),
    .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
    .AA(AA), .AB(AB), .DA(DA), .DB(DB), .QA(QA), .QB(QB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_last(out_last)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 32'hC000_0000 | 32'(a);
  endfunction

  // Registered-read SRAM: data appears the cycle after the enabled edge, otherwise holds.
  always @(posedge CLK) begin
    if (!CENA) QA <= rd(AA);
    if (!CENB) QB <= rd(AB);
  end

  // Consumer: always ready, or in pattern mode one pattern step per cycle that offers a pair.
  always @(posedge CLK) begin
    #1;
    if (ready_mode == 1 && out_valid) begin
      if (pidx < 7) out_ready = pat[pidx][0];
      else out_ready = 1'b1;
      pidx++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: address order, credit limit, hold-while-stalled, pair data and done timing.
  always @(negedge CLK) begin
    int  rel;
    bit  iss, hs;
    exp_t e;
    if (RST) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      rel = cyc - start_cyc;
      iss = !CENA;
      hs  = out_valid && out_ready;
      if (iss) begin
        if (exp_aa.size() == 0) begin
          chk("extra_issue", 1, 0);
        end else begin
          chk("aa_addr", AA, exp_aa.pop_front());
          chk("ab_addr", AB, exp_ab.pop_front());
          chk("cenb_with_cena", CENB, 0);
        end
      end
      if (out_valid && !out_ready && outst == 2) begin
        chk("cena_full_stall", CENA, 1);
        chk("cenb_full_stall", CENB, 1);
      end
      chk("outstanding_le2", (outst + int'(iss) - int'(hs)) <= 2, 1);
      outst = outst + int'(iss) - int'(hs);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_a", out_a, pa);
        chk("hold_b", out_b, pb);
        chk("hold_last", out_last, pl);
      end
      if (hs) begin
        if (sb.size() == 0) begin
          chk("extra_pair", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pair_a", out_a, e.a);
          chk("pair_b", out_b, e.b);
          chk("pair_last", out_last, e.last);
          if (e.cyc >= 0) chk("pair_cycle", rel, e.cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      pa = out_a;
      pb = out_b;
      pl = out_last;
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                          input logic [AW-1:0] sa, input logic [AW-1:0] sbs,
                          input int l, input bit timed);
    logic [AW-1:0] xa, xb;
    exp_t e;
    @(posedge CLK);
    #1;
    xa = ba;
    xb = bb;
    for (int k = 0; k < l; k++) begin
      e.a    = rd(xa);
      e.b    = rd(xb);
      e.last = (k == l - 1);
      e.cyc  = timed ? 3 + k : -1;
      sb.push_back(e);
      exp_aa.push_back(xa);
      exp_ab.push_back(xb);
      xa = xa + sa;
      xb = xb + sbs;
    end
    base_a    = ba;
    base_b    = bb;
    stride_a  = sa;
    stride_b  = sbs;
    len       = LW'(l);
    start     = 1'b1;
    start_cyc = cyc;
    done_mark = done_cnt;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_cnt == done_mark && i < budget) begin
      @(posedge CLK);
      i++;
    end
    chk({tag, "_done_seen"}, done_cnt != done_mark, 1);
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_pairs_left"}, sb.size(), 0);
    chk({tag, "_reads_left"}, exp_aa.size(), 0);
    chk({tag, "_idle_busy"}, busy, 0);
    sb.delete();
    exp_aa.delete();
    exp_ab.delete();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'(10 * (i + 1));

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cena", CENA, 1);
    chk("rst_cenb", CENB, 1);
    chk("rst_wena", WENA, 1);
    chk("rst_wenb", WENB, 1);
    chk("rst_aa", AA, 0);
    chk("rst_ab", AB, 0);
    chk("rst_da", DA, 0);
    chk("rst_db", DB, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    RST = 1'b0;

    do_start(18'd0, 18'd4, 18'd1, 18'd1, 4, 1'b1);
    wait_done("basic", 50);
    chk("basic_done_cycle", done_rel, 7);

    ready_mode = 1;
    pidx       = 0;
    do_start(18'd0, 18'd4, 18'd1, 18'd1, 4, 1'b0);
    wait_done("backpressure", 60);
    ready_mode = 0;

    do_start(18'd0, 18'd9, 18'd4, 18'd0, 3, 1'b0);
    wait_done("stride", 50);

    do_start(18'd0, 18'd0, 18'd1, 18'd1, 0, 1'b0);
    wait_done("zero_len", 20);
    chk("zero_done_cycle", done_rel, 1);

    do_start(18'd262143, 18'd20, 18'd1, 18'd1, 2, 1'b0);
    wait_done("wrap", 50);

    do_start(18'd0, 18'd4, 18'd1, 18'd1, 8, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    sb.delete();
    exp_aa.delete();
    exp_ab.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_cena", CENA, 1);
    chk("post_rst_done", done, 0);
    do_start(18'd100, 18'd200, 18'd1, 18'd1, 2, 1'b0);
    wait_done("after_reset", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
